// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and slot-to-bit-position helper for the
// 16x64 matrix row loader.
package matrix_pkg;

    localparam int ELEM_W     = 16;
    localparam int ROWS       = 16;
    localparam int COLS       = 64;
    localparam int BEAT_ELEMS = 16;

    localparam int BEAT_W = ELEM_W * BEAT_ELEMS;   // 256
    localparam int BPR    = COLS / BEAT_ELEMS;     // 4 beats per row
    localparam int TOTAL  = ROWS * BPR;            // 64 beats per matrix
    localparam int MAT_W  = ROWS * COLS * ELEM_W;  // 16384

    localparam int ROW_W      = $clog2(ROWS);
    localparam int BEAT_IDX_W = $clog2(BPR);
    localparam int POS_W      = $clog2(MAT_W);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // LSB position of the beat slot addressed by (row, beat). Slot 0 lives
    // in the MSBs, so the slot number is mirrored before scaling.
    function automatic logic [POS_W-1:0] beat_lsb(
        input logic [ROW_W-1:0]      row,
        input logic [BEAT_IDX_W-1:0] beat
    );
        logic [POS_W-1:0] slot;
        slot = (POS_W'(row) * POS_W'(BPR)) + POS_W'(beat);
        return (POS_W'(TOTAL - 1) - slot) * POS_W'(BEAT_W);
    endfunction

endpackage

// File: rtl/matrix_row_loader_16x64.sv
// Collects TOTAL narrow beats into one full matrix register and offers the
// whole matrix downstream with a valid/ready handshake. FILL accepts beats,
// FULL holds the matrix until it is consumed.
module matrix_row_loader_16x64
    import matrix_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BEAT_W-1:0]     s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [MAT_W-1:0]      m_matrix,
    output logic [ROW_W-1:0]      row_idx,
    output logic [BEAT_IDX_W-1:0] beat_idx,
    output logic                  frame_err
);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
    logic [MAT_W-1:0]        matrix_q, matrix_d;
    logic                    frame_err_q, frame_err_d;

    logic                    accept_s;
    logic                    last_beat_s;
    logic                    row_end_s;

    // Handshake qualification and position decode of the current beat slot.
    always_comb begin
        accept_s    = 1'b0;
        last_beat_s = 1'b0;
        row_end_s   = 1'b0;
        if (state_q == FILL) begin
            accept_s = s_valid;
        end else begin
            accept_s = 1'b0;
        end
        row_end_s   = (beat_q == BEAT_IDX_W'(BPR - 1));
        last_beat_s = row_end_s && (row_q == ROW_W'(ROWS - 1));
    end

    // Next-state logic: FILL -> FULL on the final beat, FULL -> FILL on consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (accept_s && last_beat_s) begin
                    state_d = FULL;
                end else begin
                    state_d = FILL;
                end
            end
            FULL: begin
                if (m_ready) begin
                    state_d = FILL;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Row/beat counters advance per accepted beat and wrap together after the final beat.
    always_comb begin
        row_d  = row_q;
        beat_d = beat_q;
        if (accept_s) begin
            if (last_beat_s) begin
                row_d  = '0;
                beat_d = '0;
            end else if (row_end_s) begin
                row_d  = row_q + ROW_W'(1);
                beat_d = '0;
            end else begin
                row_d  = row_q;
                beat_d = beat_q + BEAT_IDX_W'(1);
            end
        end else begin
            row_d  = row_q;
            beat_d = beat_q;
        end
    end

    // Matrix write: drop the accepted beat into its slot; other data is retained.
    always_comb begin
        matrix_d = matrix_q;
        if (accept_s) begin
            matrix_d[beat_lsb(row_q, beat_q) +: BEAT_W] = s_data;
        end else begin
            matrix_d = matrix_q;
        end
    end

    // Sticky framing check: s_last must coincide exactly with the final beat.
    always_comb begin
        frame_err_d = frame_err_q;
        if (accept_s && (s_last != last_beat_s)) begin
            frame_err_d = 1'b1;
        end else begin
            frame_err_d = frame_err_q;
        end
    end

    // State, counters, matrix and error flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            row_q       <= '0;
            beat_q      <= '0;
            matrix_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            beat_q      <= beat_d;
            matrix_q    <= matrix_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Handshake outputs are pure decodes of the state register, so m_ready
    // never reaches s_ready combinationally.
    assign s_ready   = (state_q == FILL);
    assign m_valid   = (state_q == FULL);
    assign m_matrix  = matrix_q;
    assign row_idx   = row_q;
    assign beat_idx  = beat_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_matrix_row_loader_16x64.sv
// Directed, table-driven bench for matrix_row_loader_16x64.
module tb_matrix_row_loader_16x64;
    import matrix_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [BEAT_W-1:0]     s_data = '0;
    logic                  s_last = 1'b0;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [MAT_W-1:0]      m_matrix;
    logic [ROW_W-1:0]      row_idx;
    logic [BEAT_IDX_W-1:0] beat_idx;
    logic                  frame_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0]       elem;
        logic              last;
        logic [BEAT_W-1:0] exp_slice;
    } vec_t;

    vec_t             tbl[TOTAL];
    logic [MAT_W-1:0] exp_mat;
    logic [MAT_W-1:0] a5_mat;

    matrix_row_loader_16x64 dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_matrix  (m_matrix),
        .row_idx   (row_idx),
        .beat_idx  (beat_idx),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_mat(input string name, input logic [MAT_W-1:0] exp);
        int bad;
        bad = -1;
        for (int k = 0; k < TOTAL; k++) begin
            if (bad < 0 && m_matrix[MAT_W-1-k*BEAT_W -: BEAT_W] !== exp[MAT_W-1-k*BEAT_W -: BEAT_W]) bad = k;
        end
        n_chk++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: slot %0d got %h expected %h", name, bad,
                     m_matrix[MAT_W-1-bad*BEAT_W -: BEAT_W], exp[MAT_W-1-bad*BEAT_W -: BEAT_W]);
        end
    endtask

    // Present one beat (after up to gap_max idle cycles), checking that the
    // counters point at slot k before it is accepted.
    task automatic send_beat(input int k, input logic [BEAT_W-1:0] data, input logic last, input int gap_max);
        int wait_cnt;
        s_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
        chk($sformatf("row_idx before beat %0d", k), BEAT_W'(row_idx), BEAT_W'(k / BPR));
        chk($sformatf("beat_idx before beat %0d", k), BEAT_W'(beat_idx), BEAT_W'(k % BPR));
        s_valid  = 1'b1;
        s_data   = data;
        s_last   = last;
        wait_cnt = 0;
        while (!s_ready && wait_cnt < 200) begin
            tick();
            wait_cnt++;
        end
        if (!s_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL s_ready timeout at beat %0d", k);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_matrix();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int pulse_at[4];
        int sent;

        for (int k = 0; k < TOTAL; k++) begin
            tbl[k].elem      = k[15:0];
            tbl[k].last      = (k == TOTAL - 1);
            tbl[k].exp_slice = {BEAT_ELEMS{k[15:0]}};
            exp_mat[MAT_W-1-k*BEAT_W -: BEAT_W] = {BEAT_ELEMS{k[15:0]}};
            a5_mat[MAT_W-1-k*BEAT_W -: BEAT_W]  = {BEAT_ELEMS{16'hA5A5}};
        end

        // ---- Reset state
        tick();
        tick();
        rst = 1'b1;
        chk("reset s_ready", BEAT_W'(s_ready), BEAT_W'(1'b1));
        chk("reset m_valid", BEAT_W'(m_valid), BEAT_W'(1'b0));
        chk("reset frame_err", BEAT_W'(frame_err), BEAT_W'(1'b0));
        chk_mat("reset m_matrix", '0);

        // ---- Test 1: continuous stream, table driven
        for (int k = 0; k < TOTAL; k++) begin
            send_beat(k, {BEAT_ELEMS{tbl[k].elem}}, tbl[k].last, 0);
            chk($sformatf("t1 m_valid after beat %0d", k), BEAT_W'(m_valid), BEAT_W'(tbl[k].last));
        end
        for (int k = 0; k < TOTAL; k++) begin
            chk($sformatf("t1 slot %0d", k), m_matrix[MAT_W-1-k*BEAT_W -: BEAT_W], tbl[k].exp_slice);
        end
        chk("t1 top slice", m_matrix[16383 -: 256], {16{16'd0}});
        chk("t1 bottom slice", m_matrix[255:0], {16{16'd63}});
        chk("t1 frame_err", BEAT_W'(frame_err), BEAT_W'(1'b0));
        chk("t1 row_idx wrapped", BEAT_W'(row_idx), BEAT_W'(0));
        chk("t1 beat_idx wrapped", BEAT_W'(beat_idx), BEAT_W'(0));

        // ---- Test 2: hold in FULL with s_valid high
        s_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            s_data = {8{$urandom()}};
            tick();
            chk("t2 s_ready held", BEAT_W'(s_ready), BEAT_W'(1'b0));
            chk("t2 m_valid held", BEAT_W'(m_valid), BEAT_W'(1'b1));
            chk_mat("t2 m_matrix stable", exp_mat);
        end
        m_ready = 1'b1;
        s_data  = {BEAT_ELEMS{16'hDEAD}};
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("t2 s_ready after release", BEAT_W'(s_ready), BEAT_W'(1'b1));
        chk("t2 m_valid after release", BEAT_W'(m_valid), BEAT_W'(1'b0));
        chk("t2 no accept in release row", BEAT_W'(row_idx), BEAT_W'(0));
        chk("t2 no accept in release beat", BEAT_W'(beat_idx), BEAT_W'(0));
        chk_mat("t2 matrix kept after release", exp_mat);

        // ---- Test 3: random gaps, same data
        for (int k = 0; k < TOTAL; k++) begin
            send_beat(k, {BEAT_ELEMS{tbl[k].elem}}, tbl[k].last, 2);
        end
        chk("t3 m_valid", BEAT_W'(m_valid), BEAT_W'(1'b1));
        chk_mat("t3 m_matrix", exp_mat);
        chk("t3 frame_err", BEAT_W'(frame_err), BEAT_W'(1'b0));
        release_matrix();

        // ---- Test 4: early s_last on beat 20
        for (int k = 0; k < TOTAL; k++) begin
            send_beat(k, {BEAT_ELEMS{tbl[k].elem}}, (k == 20) || (k == TOTAL - 1), 0);
            if (k == 19) chk("t4 frame_err before 20", BEAT_W'(frame_err), BEAT_W'(1'b0));
            if (k == 20) chk("t4 frame_err at 20", BEAT_W'(frame_err), BEAT_W'(1'b1));
            if (k == 20) chk("t4 not complete at 20", BEAT_W'(m_valid), BEAT_W'(1'b0));
        end
        chk("t4 completes at 63", BEAT_W'(m_valid), BEAT_W'(1'b1));
        release_matrix();
        for (int k = 0; k < TOTAL; k++) begin
            send_beat(k, {BEAT_ELEMS{tbl[k].elem}}, tbl[k].last, 0);
        end
        chk("t4 clean frame done", BEAT_W'(m_valid), BEAT_W'(1'b1));
        chk("t4 frame_err sticky", BEAT_W'(frame_err), BEAT_W'(1'b1));
        release_matrix();

        // ---- Test 5: reset mid-frame, then restream 0xA5A5
        for (int k = 0; k <= 30; k++) begin
            send_beat(k, {BEAT_ELEMS{tbl[k].elem}}, 1'b0, 0);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_mat("t5 matrix zeroed", '0);
        chk("t5 row_idx reset", BEAT_W'(row_idx), BEAT_W'(0));
        chk("t5 beat_idx reset", BEAT_W'(beat_idx), BEAT_W'(0));
        chk("t5 frame_err reset", BEAT_W'(frame_err), BEAT_W'(1'b0));
        chk("t5 s_ready reset", BEAT_W'(s_ready), BEAT_W'(1'b1));
        for (int k = 0; k < TOTAL; k++) begin
            send_beat(k, {BEAT_ELEMS{16'hA5A5}}, tbl[k].last, 0);
        end
        chk("t5 m_valid", BEAT_W'(m_valid), BEAT_W'(1'b1));
        chk_mat("t5 all A5A5", a5_mat);
        chk("t5 frame_err", BEAT_W'(frame_err), BEAT_W'(1'b0));
        release_matrix();

        // ---- Test 6: three back-to-back frames, m_ready tied high
        m_ready = 1'b1;
        pulses  = 0;
        sent    = 0;
        for (int c = 0; c < 3 * (TOTAL + 1) + 20; c++) begin
            if (m_valid) begin
                if (pulses < 4) pulse_at[pulses] = c;
                pulses++;
            end
            if (s_ready && sent < 3 * TOTAL) begin
                s_valid = 1'b1;
                s_data  = {BEAT_ELEMS{16'(sent)}};
                s_last  = ((sent % TOTAL) == TOTAL - 1);
                sent++;
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("t6 pulse count", BEAT_W'(pulses), BEAT_W'(3));
        if (pulses >= 3) begin
            chk("t6 first pulse", BEAT_W'(pulse_at[0]), BEAT_W'(TOTAL));
            chk("t6 gap 1", BEAT_W'(pulse_at[1] - pulse_at[0]), BEAT_W'(TOTAL + 1));
            chk("t6 gap 2", BEAT_W'(pulse_at[2] - pulse_at[1]), BEAT_W'(TOTAL + 1));
        end
        chk("t6 frame_err", BEAT_W'(frame_err), BEAT_W'(1'b0));
        chk("t6 last frame bottom slice", m_matrix[255:0], {BEAT_ELEMS{16'(3 * TOTAL - 1)}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
